// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a byte-addressed, 4-byte-wide data memory.
// States: IDLE accept | LOAD read+extend | RMW_RD fetch old word | STORE write | RESP hold response.
module load_store_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ADDR_MAX = 32'h1FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] RMW_RD = 3'd2;
    localparam logic [2:0] STORE  = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [2:0]       f3_q, f3_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic [WIDTH-1:0] old_q, old_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             legal_f3;
    logic [WIDTH:0]   span_m1;
    logic [WIDTH:0]   last_addr;
    logic             out_of_range;
    logic [WIDTH-1:0] load_ext;

    // Stores always touch A..A+3 (sub-word ones via read-modify-write), so they range-check as 4 bytes.
    always_comb begin
        span_m1 = '0;
        if (req_we) begin
            span_m1 = (WIDTH+1)'(3);
        end else begin
            case (req_funct3[1:0])
                2'b00:   span_m1 = '0;
                2'b01:   span_m1 = (WIDTH+1)'(1);
                default: span_m1 = (WIDTH+1)'(3);
            endcase
        end
    end

    always_comb begin
        legal_f3 = 1'b0;
        if (req_we) begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010)
                    || (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
    end

    assign last_addr    = {1'b0, req_addr} + span_m1;
    assign out_of_range = last_addr > {1'b0, ADDR_MAX};

    always_comb begin
        load_ext = mem_rd;
        case (f3_q[1:0])
            2'b00:   load_ext = {{(WIDTH-8){mem_rd[7] & ~f3_q[2]}}, mem_rd[7:0]};
            2'b01:   load_ext = {{(WIDTH-16){mem_rd[15] & ~f3_q[2]}}, mem_rd[15:0]};
            default: load_ext = mem_rd;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wd_d    = wd_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    wd_d    = req_wdata;
                    old_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (!legal_f3 || out_of_range) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_ext;
                state_d = RESP;
            end
            RMW_RD: begin
                old_d   = mem_rd;
                state_d = STORE;
            end
            STORE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            wd_q    <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wd_q    <= wd_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Write data merges the new low bytes into the fetched word; byte A sits in bits 7:0.
    always_comb begin
        mem_wd = '0;
        if (state_q == STORE) begin
            case (f3_q[1:0])
                2'b00:   mem_wd = {old_q[WIDTH-1:8], wd_q[7:0]};
                2'b01:   mem_wd = {old_q[WIDTH-1:16], wd_q[15:0]};
                default: mem_wd = wd_q;
            endcase
        end
    end

    assign mem_we    = (state_q == STORE);
    assign mem_a     = (state_q == IDLE) ? '0 : addr_q;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model behind the memory port.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [7:0]  mem [0:32'h20002];
    logic        pl_en;
    logic [31:0] pl_addr, pl_data;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int we_base = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_wd = '0;

    load_store_unit #(.WIDTH(32), .ADDR_MAX(32'h1FFFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < 4; i++) mem[int'(pl_addr) + i] <= pl_data[8*i +: 8];
        end else if (mem_we === 1'b1) begin
            for (int i = 0; i < 4; i++) mem[int'(mem_a & 32'h1FFFF) + i] <= mem_wd[8*i +: 8];
        end
    end

    always_comb begin
        int ma;
        ma = int'(mem_a & 32'h1FFFF);
        mem_rd = {mem[ma+3], mem[ma+2], mem[ma+1], mem[ma]};
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_cnt  <= we_cnt + 1;
            last_a  <= mem_a;
            last_wd <= mem_wd;
        end
    end

    function automatic logic [31:0] rdword(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        we_base    = we_cnt;
        req_valid  = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
    endtask

    task automatic finish_txn(input string tag, input int exp_lat, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_we);
        int lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        check({tag, "_wecnt"}, 32'(we_cnt - we_base), 32'(exp_we));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_done"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_we);
        issue(tag, we, f3, a, wd);
        finish_txn(tag, exp_lat, exp_rdata, exp_err, exp_we);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);

        preload(32'h10000, 32'h12345678);
        preload(32'h10004, 32'hDDCCBBAA);
        preload(32'h10008, 32'h00000000);
        preload(32'h1000C, 32'h00000000);
        preload(32'h1FFFC, 32'hA5000000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn("lw", 1'b0, 3'b010, 32'h10000, '0, 2, 32'h12345678, 1'b0, 0);

        preload(32'h10000, 32'h80015678);
        txn("lb", 1'b0, 3'b000, 32'h10003, '0, 2, 32'hFFFFFF80, 1'b0, 0);
        txn("lbu", 1'b0, 3'b100, 32'h10003, '0, 2, 32'h00000080, 1'b0, 0);
        txn("lh", 1'b0, 3'b001, 32'h10002, '0, 2, 32'hFFFF8001, 1'b0, 0);
        txn("lhu", 1'b0, 3'b101, 32'h10002, '0, 2, 32'h00008001, 1'b0, 0);
        txn("lh_misal", 1'b0, 3'b001, 32'h10001, '0, 2, 32'h00000156, 1'b0, 0);

        preload(32'h10000, 32'h12345678);
        txn("sb", 1'b1, 3'b000, 32'h10001, 32'hFFFFFFAB, 3, 32'h0, 1'b0, 1);
        check("sb_mem_a", last_a, 32'h00010001);
        check("sb_mem_wd", last_wd, 32'hAA1234AB);
        check("sb_word0", rdword(32'h10000), 32'h1234AB78);
        check("sb_word1", rdword(32'h10004), 32'hDDCCBBAA);

        txn("sw", 1'b1, 3'b010, 32'h10008, 32'hCAFEF00D, 2, 32'h0, 1'b0, 1);
        check("sw_word", rdword(32'h10008), 32'hCAFEF00D);
        txn("lw_back", 1'b0, 3'b010, 32'h10008, '0, 2, 32'hCAFEF00D, 1'b0, 0);

        txn("sh", 1'b1, 3'b001, 32'h1000A, 32'hFFFF1234, 3, 32'h0, 1'b0, 1);
        check("sh_mem_wd", last_wd, 32'h00001234);
        check("sh_word", rdword(32'h10008), 32'h1234F00D);
        check("sh_word_next", rdword(32'h1000C), 32'h00000000);

        txn("lw_oor", 1'b0, 3'b010, 32'h1FFFE, '0, 1, 32'h0, 1'b1, 0);
        txn("ld_f3_011", 1'b0, 3'b011, 32'h10000, '0, 1, 32'h0, 1'b1, 0);
        txn("st_f3_100", 1'b1, 3'b100, 32'h10000, 32'h5, 1, 32'h0, 1'b1, 0);
        txn("sb_oor", 1'b1, 3'b000, 32'h1FFFE, 32'h5, 1, 32'h0, 1'b1, 0);
        txn("lhu_oor", 1'b0, 3'b101, 32'h1FFFF, '0, 1, 32'h0, 1'b1, 0);
        check("oor_word", rdword(32'h1FFFC), 32'hA5000000);
        txn("sb_top", 1'b1, 3'b000, 32'h1FFFC, 32'h12345677, 3, 32'h0, 1'b0, 1);
        check("sb_top_word", rdword(32'h1FFFC), 32'hA5000077);
        txn("lb_top", 1'b0, 3'b000, 32'h1FFFF, '0, 2, 32'hFFFFFFA5, 1'b0, 0);
        txn("lbu_top", 1'b0, 3'b100, 32'h1FFFF, '0, 2, 32'h000000A5, 1'b0, 0);

        // Response held off for four cycles, then a request presented alongside the handshake.
        issue("hold", 1'b0, 3'b010, 32'h10000, '0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, 32'h1234AB78);
            check("hold_err", {31'd0, rsp_err}, 32'd0);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h10001; req_wdata = '0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("b2b_after_hs", {30'd0, rsp_valid, req_ready}, 32'd1);
        we_base = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_accepted", {31'd0, req_ready}, 32'd0);
        finish_txn("b2b", 2, 32'h000000AB, 1'b0, 0);

        // Reset dropped while the SH is fetching its old word.
        issue("sh_rst", 1'b1, 3'b001, 32'h10000, 32'h00009999);
        check("sh_rst_mem_a", mem_a, 32'h00010000);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_ready", {31'd0, req_ready}, 32'd1);
        check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_mem_a", mem_a, 32'd0);
        check("arst_mem_we", {31'd0, mem_we}, 32'd0);
        check("arst_mem_wd", mem_wd, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("arst_wecnt", 32'(we_cnt - we_base), 32'd0);
        check("arst_word", rdword(32'h10000), 32'h1234AB78);
        @(posedge clk); #1;
        txn("lw_post_rst", 1'b0, 3'b010, 32'h10000, '0, 2, 32'h1234AB78, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
